// File: rtl/mouse_position_tracker_if.sv
// Bundle of packet, position-load and tracker result signals between the
// mouse packet decoder (master) and the position tracker (slave).
interface mouse_position_tracker_if #(
  parameter int COORD_W = 10
);
  logic               PKT_VALID;
  logic [7:0]         PKT_STATUS;
  logic [7:0]         PKT_DX;
  logic [7:0]         PKT_DY;
  logic [3:0]         PKT_DZ;
  logic               SET_POS;
  logic [COORD_W-1:0] SET_X;
  logic [COORD_W-1:0] SET_Y;
  logic [COORD_W-1:0] MOUSE_X;
  logic [COORD_W-1:0] MOUSE_Y;
  logic [7:0]         WHEEL_POS;
  logic [2:0]         BUTTONS;
  logic [2:0]         BTN_PRESS;
  logic [2:0]         BTN_RELEASE;
  logic               MOVED;

  modport master (
    output PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY, PKT_DZ,
    output SET_POS, SET_X, SET_Y,
    input  MOUSE_X, MOUSE_Y, WHEEL_POS, BUTTONS, BTN_PRESS, BTN_RELEASE, MOVED
  );

  modport slave (
    input  PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY, PKT_DZ,
    input  SET_POS, SET_X, SET_Y,
    output MOUSE_X, MOUSE_Y, WHEEL_POS, BUTTONS, BTN_PRESS, BTN_RELEASE, MOVED
  );
endinterface

// File: rtl/mouse_position_tracker.sv
// Absolute cursor tracker fed by decoded PS/2 mouse packets.
// Two-stage pipeline: stage 1 decodes/scales the deltas, stage 2 commits
// position (clamp or wrap), wheel accumulator and button edge pulses.
module mouse_position_tracker #(
  parameter int COORD_W     = 10,
  parameter int LIMIT_X     = 640,
  parameter int LIMIT_Y     = 480,
  parameter int WRAP        = 0,
  parameter int INVERT_Y    = 1,
  parameter int SPEED_SHIFT = 0
) (
  input logic                       CLK,
  input logic                       RESET,
  mouse_position_tracker_if.slave   bus_io
);

  localparam int DW = 10 + SPEED_SHIFT;
  localparam int NW = COORD_W + SPEED_SHIFT + 2;

  localparam logic signed [NW-1:0]  LIM_XS = NW'(LIMIT_X);
  localparam logic signed [NW-1:0]  LIM_YS = NW'(LIMIT_Y);
  localparam logic [COORD_W-1:0]    MAX_X  = COORD_W'(LIMIT_X - 1);
  localparam logic [COORD_W-1:0]    MAX_Y  = COORD_W'(LIMIT_Y - 1);
  localparam logic [COORD_W-1:0]    RST_X  = COORD_W'(LIMIT_X / 2);
  localparam logic [COORD_W-1:0]    RST_Y  = COORD_W'(LIMIT_Y / 2);

  // 9-bit signed delta from sign + magnitude; overflow saturates to the extreme.
  function automatic logic signed [8:0] decode_delta(input logic sgn, input logic ovf,
                                                      input logic [7:0] mag);
    if (ovf) decode_delta = sgn ? 9'sh100 : 9'sh0FF;
    else     decode_delta = {sgn, mag};
  endfunction

  // Fold a candidate coordinate back into 0..lim-1. Wrap handles one lap;
  // the trailing clamp catches deltas large enough to cross more than one.
  function automatic logic [COORD_W-1:0] fit_coord(input logic signed [NW-1:0] v,
                                                   input logic signed [NW-1:0] lim);
    logic signed [NW-1:0] t;
    t = v;
    if (WRAP != 0) begin
      if (t[NW-1])       t = t + lim;
      else if (t >= lim) t = t - lim;
    end
    if (t[NW-1])               t = '0;
    else if (t > lim - NW'(1)) t = lim - NW'(1);
    return t[COORD_W-1:0];
  endfunction

  // Status bit 3 is the PS/2 always-one framing bit and carries no data.
  logic unused_status_bit3;
  assign unused_status_bit3 = bus_io.PKT_STATUS[3];

  logic signed [8:0]    dx9, dy9;
  logic signed [9:0]    dx10, dy10;
  logic signed [DW-1:0] s1_dx_d, s1_dy_d;
  logic [7:0]           s1_dz_d;

  logic                 s1_v_q;
  logic signed [DW-1:0] s1_dx_q, s1_dy_q;
  logic [7:0]           s1_dz_q;
  logic [2:0]           s1_btn_q;

  logic [COORD_W-1:0]   x_q, y_q, x_d, y_d;
  logic [7:0]           wheel_q, wheel_d;
  logic [2:0]           btn_q, btn_d;
  logic [2:0]           press_q, press_d;
  logic [2:0]           rel_q, rel_d;
  logic                 moved_q, moved_d;

  logic signed [NW-1:0] new_x, new_y;
  logic [COORD_W-1:0]   set_x_c, set_y_c;
  logic signed [8:0]    wheel_sum;
  logic [7:0]           wheel_sat;

  // Stage 1 decode: sign/overflow, optional Y inversion, speed scaling, DZ extension.
  always_comb begin
    dx9     = decode_delta(bus_io.PKT_STATUS[4], bus_io.PKT_STATUS[6], bus_io.PKT_DX);
    dy9     = decode_delta(bus_io.PKT_STATUS[5], bus_io.PKT_STATUS[7], bus_io.PKT_DY);
    dx10    = 10'(dx9);
    dy10    = (INVERT_Y != 0) ? -(10'(dy9)) : 10'(dy9);
    s1_dx_d = DW'(dx10) <<< SPEED_SHIFT;
    s1_dy_d = DW'(dy10) <<< SPEED_SHIFT;
    s1_dz_d = {{4{bus_io.PKT_DZ[3]}}, bus_io.PKT_DZ};
  end

  // Stage 2 commit: new position, saturating wheel, button edges, SET_POS override.
  always_comb begin
    new_x     = $signed(NW'({1'b0, x_q})) + NW'(s1_dx_q);
    new_y     = $signed(NW'({1'b0, y_q})) + NW'(s1_dy_q);
    set_x_c   = (bus_io.SET_X > MAX_X) ? MAX_X : bus_io.SET_X;
    set_y_c   = (bus_io.SET_Y > MAX_Y) ? MAX_Y : bus_io.SET_Y;
    wheel_sum = $signed({wheel_q[7], wheel_q}) + $signed({s1_dz_q[7], s1_dz_q});
    if (wheel_sum[8] != wheel_sum[7]) wheel_sat = wheel_sum[8] ? 8'h80 : 8'h7F;
    else                              wheel_sat = wheel_sum[7:0];

    x_d     = x_q;
    y_d     = y_q;
    wheel_d = wheel_q;
    btn_d   = btn_q;
    press_d = 3'b000;
    rel_d   = 3'b000;
    moved_d = 1'b0;
    if (s1_v_q) begin
      x_d     = fit_coord(new_x, LIM_XS);
      y_d     = fit_coord(new_y, LIM_YS);
      wheel_d = wheel_sat;
      btn_d   = s1_btn_q;
      press_d = s1_btn_q & ~btn_q;
      rel_d   = ~s1_btn_q & btn_q;
      moved_d = 1'b1;
    end
    if (bus_io.SET_POS) begin
      x_d = set_x_c;
      y_d = set_y_c;
    end
  end

  // Pipeline and output registers; reset drops any packet in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_v_q   <= 1'b0;
      s1_dx_q  <= '0;
      s1_dy_q  <= '0;
      s1_dz_q  <= '0;
      s1_btn_q <= '0;
      x_q      <= RST_X;
      y_q      <= RST_Y;
      wheel_q  <= '0;
      btn_q    <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      moved_q  <= 1'b0;
    end else begin
      s1_v_q   <= bus_io.PKT_VALID;
      s1_dx_q  <= s1_dx_d;
      s1_dy_q  <= s1_dy_d;
      s1_dz_q  <= s1_dz_d;
      s1_btn_q <= bus_io.PKT_STATUS[2:0];
      x_q      <= x_d;
      y_q      <= y_d;
      wheel_q  <= wheel_d;
      btn_q    <= btn_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      moved_q  <= moved_d;
    end
  end

  assign bus_io.MOUSE_X     = x_q;
  assign bus_io.MOUSE_Y     = y_q;
  assign bus_io.WHEEL_POS   = wheel_q;
  assign bus_io.BUTTONS     = btn_q;
  assign bus_io.BTN_PRESS   = press_q;
  assign bus_io.BTN_RELEASE = rel_q;
  assign bus_io.MOVED       = moved_q;

endmodule
